// File: rtl/dqs_calib_pkg.sv
// Shared types and constants for the read-DQS delay calibration controller.
package dqs_calib_pkg;

  localparam int TAP_W    = 3;
  localparam int NUM_TAPS = 8;

  localparam logic [TAP_W-1:0] DEFAULT_TAP = 3'd3;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    ISSUE,
    WAIT,
    NEXT,
    EVAL,
    APPLY
  } state_e;

endpackage

// File: rtl/dqs_win_find.sv
// Sequential longest-run scanner over the tap pass map, one tap per cycle.
// rdy marks the last scan step; best_start/best_len are final on the next cycle.
module dqs_win_find
  import dqs_calib_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_TAPS-1:0] pass_map_i,
  input  logic                go_i,
  output logic [TAP_W-1:0]    best_start_o,
  output logic [TAP_W:0]      best_len_o,
  output logic                rdy_o
);

  logic [NUM_TAPS-1:0] map_q, map_d;
  logic [TAP_W-1:0]    idx_q, idx_d;
  logic                act_q, act_d;
  logic [TAP_W-1:0]    cs_q, cs_d;
  logic [TAP_W:0]      cl_q, cl_d;
  logic [TAP_W-1:0]    bs_q, bs_d;
  logic [TAP_W:0]      bl_q, bl_d;
  logic [TAP_W-1:0]    run_s;
  logic [TAP_W:0]      run_l;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      map_q <= '0;
      idx_q <= '0;
      act_q <= 1'b0;
      cs_q  <= '0;
      cl_q  <= '0;
      bs_q  <= '0;
      bl_q  <= '0;
    end else begin
      map_q <= map_d;
      idx_q <= idx_d;
      act_q <= act_d;
      cs_q  <= cs_d;
      cl_q  <= cl_d;
      bs_q  <= bs_d;
      bl_q  <= bl_d;
    end
  end

  always_comb begin
    map_d = map_q;
    idx_d = idx_q;
    act_d = act_q;
    cs_d  = cs_q;
    cl_d  = cl_q;
    bs_d  = bs_q;
    bl_d  = bl_q;
    run_s = cs_q;
    run_l = cl_q;
    if (go_i) begin
      map_d = pass_map_i;
      idx_d = '0;
      act_d = 1'b1;
      cs_d  = '0;
      cl_d  = '0;
      bs_d  = '0;
      bl_d  = '0;
    end else if (act_q) begin
      if (map_q[idx_q]) begin
        if (cl_q == '0) begin
          run_s = idx_q;
          run_l = 4'd1;
        end else begin
          run_s = cs_q;
          run_l = cl_q + 4'd1;
        end
        cs_d = run_s;
        cl_d = run_l;
        // Strictly longer only, so an equal later run keeps the lower start
        if (run_l > bl_q) begin
          bs_d = run_s;
          bl_d = run_l;
        end
      end else begin
        cl_d = '0;
      end
      idx_d = idx_q + 3'd1;
      if (idx_q == 3'(NUM_TAPS - 1)) act_d = 1'b0;
    end
  end

  assign best_start_o = bs_q;
  assign best_len_o   = bl_q;
  assign rdy_o        = act_q && (idx_q == 3'(NUM_TAPS - 1));

endmodule

// File: rtl/dqs_dly_calib.sv
// Read-DQS delay calibration: sweeps all taps with training reads,
// then centres the delay buffer on the longest passing window.
module dqs_dly_calib #(
  parameter int unsigned SETTLE_CYCLES   = 4,
  parameter int unsigned SAMPLES_PER_TAP = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 64,
  parameter logic [dqs_calib_pkg::TAP_W-1:0] DEFAULT_TAP =
    dqs_calib_pkg::DEFAULT_TAP
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  output logic                            trig_rd,
  input  logic                            cmp_valid,
  input  logic                            cmp_pass,
  output logic [dqs_calib_pkg::TAP_W-1:0] dly_sel,
  output logic                            busy,
  output logic                            done,
  output logic                            fail,
  output logic [dqs_calib_pkg::NUM_TAPS-1:0] pass_map,
  output logic [dqs_calib_pkg::TAP_W-1:0] win_first,
  output logic [dqs_calib_pkg::TAP_W-1:0] win_last
);

  import dqs_calib_pkg::*;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e              state_q, state_d;
  logic [TAP_W-1:0]    tap_q, tap_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [7:0]          smp_q, smp_d;
  logic                flag_q, flag_d;
  logic [NUM_TAPS-1:0] map_q, map_d;
  logic                done_q, done_d;
  logic                fail_q, fail_d;
  logic [TAP_W-1:0]    dly_q, dly_d;
  logic [TAP_W-1:0]    wf_q, wf_d;
  logic [TAP_W-1:0]    wl_q, wl_d;

  logic                win_go;
  logic                win_rdy;
  logic [TAP_W-1:0]    best_start;
  logic [TAP_W:0]      best_len;

  dqs_win_find u_win_find (
    .clk          (clk),
    .rst          (rst),
    .pass_map_i   (map_d),
    .go_i         (win_go),
    .best_start_o (best_start),
    .best_len_o   (best_len),
    .rdy_o        (win_rdy)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      tap_q   <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      smp_q   <= '0;
      flag_q  <= 1'b0;
      map_q   <= '0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      dly_q   <= DEFAULT_TAP;
      wf_q    <= '0;
      wl_q    <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      smp_q   <= smp_d;
      flag_q  <= flag_d;
      map_q   <= map_d;
      done_q  <= done_d;
      fail_q  <= fail_d;
      dly_q   <= dly_d;
      wf_q    <= wf_d;
      wl_q    <= wl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    smp_d   = smp_q;
    flag_d  = flag_q;
    map_d   = map_q;
    done_d  = done_q;
    fail_d  = fail_q;
    dly_d   = dly_q;
    wf_d    = wf_q;
    wl_d    = wl_q;
    win_go  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          fail_d  = 1'b0;
          map_d   = '0;
          tap_d   = '0;
          dly_d   = '0;
          cnt_d   = '0;
          smp_d   = '0;
          flag_d  = 1'b0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (cnt_q == 4'(SETTLE_CYCLES - 1)) begin
          cnt_d   = '0;
          state_d = ISSUE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ISSUE: begin
        tmo_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A response in the timeout cycle still counts as a response
        if (cmp_valid || tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          if (!(cmp_valid && cmp_pass)) flag_d = 1'b1;
          if (smp_q == 8'(SAMPLES_PER_TAP - 1)) begin
            smp_d   = '0;
            state_d = NEXT;
          end else begin
            smp_d   = smp_q + 8'd1;
            state_d = ISSUE;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      NEXT: begin
        map_d[tap_q] = ~flag_q;
        flag_d       = 1'b0;
        if (tap_q == 3'(NUM_TAPS - 1)) begin
          win_go  = 1'b1;
          state_d = EVAL;
        end else begin
          tap_d   = tap_q + 3'd1;
          dly_d   = tap_q + 3'd1;
          state_d = SETTLE;
        end
      end
      EVAL: begin
        if (win_rdy) state_d = APPLY;
      end
      APPLY: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (best_len == '0) begin
          fail_d = 1'b1;
          dly_d  = DEFAULT_TAP;
          wf_d   = '0;
          wl_d   = '0;
        end else begin
          wf_d  = best_start;
          wl_d  = best_start + 3'(best_len - 4'd1);
          dly_d = best_start + 3'((best_len - 4'd1) >> 1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    trig_rd = (state_q == ISSUE);
    busy    = (state_q != IDLE);
  end

  assign dly_sel   = dly_q;
  assign done      = done_q;
  assign fail      = fail_q;
  assign pass_map  = map_q;
  assign win_first = wf_q;
  assign win_last  = wl_q;

endmodule

// File: tb/tb_dqs_dly_calib.sv
// Scoreboard bench for dqs_dly_calib with a behavioural compare responder.
module tb_dqs_dly_calib;

  localparam int TMO = 64;
  localparam int BOUND = 6000;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       trig_rd;
  logic       cmp_valid;
  logic       cmp_pass;
  logic [2:0] dly_sel;
  logic       busy;
  logic       done;
  logic       fail;
  logic [7:0] pass_map;
  logic [2:0] win_first;
  logic [2:0] win_last;

  always #5 clk = ~clk;

  dqs_dly_calib dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .trig_rd   (trig_rd),
    .cmp_valid (cmp_valid),
    .cmp_pass  (cmp_pass),
    .dly_sel   (dly_sel),
    .busy      (busy),
    .done      (done),
    .fail      (fail),
    .pass_map  (pass_map),
    .win_first (win_first),
    .win_last  (win_last)
  );

  typedef struct packed {
    logic       fl;
    logic [7:0] map;
    logic [2:0] wf;
    logic [2:0] wl;
    logic [2:0] dly;
  } res_t;

  res_t sb[$];
  int   npass = 0;
  int   ntot  = 0;

  // responder config: 0 = pass, 1 = fail, 2 = silent
  int   mode[8];
  int   bad_tap = -1;
  int   bad_idx = 0;
  bit   spur_en = 0;

  int   scnt[8];
  int   trig_cnt = 0;
  int   cyc = 0;
  int   prev0 = 0;
  int   min_gap0 = 1000000;
  bit   have0 = 0;
  logic pend;
  logic ppass;
  logic prev_busy;
  logic [2:0] last_dly;

  initial begin
    cmp_valid = 1'b0;
    cmp_pass  = 1'b0;
    pend      = 1'b0;
    ppass     = 1'b0;
    prev_busy = 1'b0;
    last_dly  = 3'd3;
    for (int i = 0; i < 8; i++) scnt[i] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      cmp_valid = 1'b0;
      cmp_pass  = 1'b0;
      if (rst) begin
        pend     = 1'b0;
        last_dly = dly_sel;
      end else begin
        if (busy && !prev_busy) begin
          for (int i = 0; i < 8; i++) scnt[i] = 0;
          have0    = 0;
          min_gap0 = 1000000;
        end
        if (pend) begin
          cmp_valid = 1'b1;
          cmp_pass  = ppass;
          pend      = 1'b0;
        end
        if (trig_rd) begin
          int t;
          t = int'(dly_sel);
          trig_cnt++;
          if (t == 0) begin
            if (have0 && (cyc - prev0) < min_gap0) min_gap0 = cyc - prev0;
            have0 = 1;
            prev0 = cyc;
          end
          if (mode[t] != 2) begin
            pend  = 1'b1;
            ppass = (mode[t] == 0) && !(t == bad_tap && scnt[t] == bad_idx);
          end
          scnt[t]++;
        end
        if (spur_en && busy && dly_sel != last_dly && !cmp_valid) begin
          cmp_valid = 1'b1;
          cmp_pass  = 1'b0;
        end
        last_dly = dly_sel;
      end
      prev_busy = busy;
    end
  end

  function automatic res_t obs();
    return res_t'({fail, pass_map, win_first, win_last, dly_sel});
  endfunction

  task automatic set_modes(input logic [7:0] pm);
    for (int i = 0; i < 8; i++) mode[i] = pm[i] ? 0 : 1;
    bad_tap = -1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ntot++;
    if (dly_sel !== 3'd3)
      $display("FAIL reset_dly: got %0d want 3", dly_sel);
    else npass++;
    ntot++;
    if ({trig_rd, busy, done, fail, pass_map, win_first, win_last} !== '0)
      $display("FAIL reset_outs: got t%b b%b d%b f%b m%h wf%0d wl%0d want 0",
               trig_rd, busy, done, fail, pass_map, win_first, win_last);
    else npass++;
  endtask

  task automatic test_all_pass();
    bit ok;
    int base;
    res_t e, o;
    set_modes(8'hFF);
    spur_en = 1;
    base = trig_cnt;
    sb.push_back('{1'b0, 8'hFF, 3'd0, 3'd7, 3'd3});
    pulse_start();
    ntot++;
    if (busy !== 1'b1) $display("FAIL busy_after_start: got %b want 1", busy);
    else npass++;
    wait_done(ok);
    e = sb.pop_front();
    o = obs();
    ntot++;
    if (!ok || o !== e)
      $display("FAIL all_pass: got %h done=%0d want %h", o, ok, e);
    else npass++;
    ntot++;
    if (trig_cnt - base != 128)
      $display("FAIL all_pass_trigs: got %0d want 128", trig_cnt - base);
    else npass++;
    spur_en = 0;
    repeat (10) @(negedge clk);
    ntot++;
    if (done !== 1'b1 || busy !== 1'b0 || obs() !== e)
      $display("FAIL done_hold: got d%b b%b %h want d1 b0 %h",
               done, busy, obs(), e);
    else npass++;
  endtask

  task automatic test_window_mid();
    bit ok;
    res_t e, o;
    set_modes(8'h3C);
    sb.push_back('{1'b0, 8'h3C, 3'd2, 3'd5, 3'd3});
    pulse_start();
    wait_done(ok);
    e = sb.pop_front();
    o = obs();
    ntot++;
    if (!ok || o !== e)
      $display("FAIL window_mid: got %h done=%0d want %h", o, ok, e);
    else npass++;
  endtask

  task automatic test_two_windows();
    bit ok;
    res_t e, o;
    set_modes(8'h73);
    sb.push_back('{1'b0, 8'h73, 3'd4, 3'd6, 3'd5});
    pulse_start();
    wait_done(ok);
    e = sb.pop_front();
    o = obs();
    ntot++;
    if (!ok || o !== e)
      $display("FAIL longer_window: got %h done=%0d want %h", o, ok, e);
    else npass++;
    set_modes(8'hE7);
    sb.push_back('{1'b0, 8'hE7, 3'd0, 3'd2, 3'd1});
    pulse_start();
    wait_done(ok);
    e = sb.pop_front();
    o = obs();
    ntot++;
    if (!ok || o !== e)
      $display("FAIL tie_window: got %h done=%0d want %h", o, ok, e);
    else npass++;
  endtask

  task automatic test_no_pass();
    bit ok;
    res_t e, o;
    set_modes(8'h00);
    sb.push_back('{1'b1, 8'h00, 3'd0, 3'd0, 3'd3});
    pulse_start();
    wait_done(ok);
    e = sb.pop_front();
    o = obs();
    ntot++;
    if (!ok || o !== e)
      $display("FAIL no_pass: got %h done=%0d want %h", o, ok, e);
    else npass++;
  endtask

  task automatic test_bad_sample();
    bit ok;
    res_t e, o;
    set_modes(8'hFF);
    bad_tap = 7;
    bad_idx = 5;
    sb.push_back('{1'b0, 8'h7F, 3'd0, 3'd6, 3'd3});
    pulse_start();
    wait_done(ok);
    e = sb.pop_front();
    o = obs();
    ntot++;
    if (!ok || o !== e)
      $display("FAIL bad_sample: got %h done=%0d want %h", o, ok, e);
    else npass++;
    bad_tap = -1;
  endtask

  task automatic test_timeout();
    bit ok;
    int base;
    res_t e, o;
    set_modes(8'hFF);
    mode[0] = 2;
    base = trig_cnt;
    sb.push_back('{1'b0, 8'hFE, 3'd1, 3'd7, 3'd4});
    pulse_start();
    wait_done(ok);
    e = sb.pop_front();
    o = obs();
    ntot++;
    if (!ok || o !== e)
      $display("FAIL timeout_tap0: got %h done=%0d want %h", o, ok, e);
    else npass++;
    ntot++;
    if (trig_cnt - base != 128)
      $display("FAIL timeout_trigs: got %0d want 128", trig_cnt - base);
    else npass++;
    ntot++;
    if (min_gap0 < TMO)
      $display("FAIL timeout_gap: got %0d want >= %0d", min_gap0, TMO);
    else npass++;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int base;
    set_modes(8'hFF);
    pulse_start();
    ok = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (dly_sel == 3'd4 && trig_rd) begin
        ok = 1;
        break;
      end
    end
    #2 rst = 1'b1;
    #1;
    ntot++;
    if (!ok || busy !== 1'b0 || dly_sel !== 3'd3 || trig_rd !== 1'b0)
      $display("FAIL async_rst: got reached=%0d b%b dly%0d t%b want 1 b0 dly3 t0",
               ok, busy, dly_sel, trig_rd);
    else npass++;
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    base = trig_cnt;
    repeat (40) @(negedge clk);
    ntot++;
    if (trig_cnt != base || busy !== 1'b0 || done !== 1'b0 || pass_map !== 8'h00)
      $display("FAIL post_rst_idle: got trigs=%0d b%b d%b m%h want 0 b0 d0 m00",
               trig_cnt - base, busy, done, pass_map);
    else npass++;
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    res_t e, o;
    set_modes(8'hFF);
    base = trig_cnt;
    sb.push_back('{1'b0, 8'hFF, 3'd0, 3'd7, 3'd3});
    pulse_start();
    ok = 0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge clk);
      if (dly_sel == 3'd2) begin
        ok = 1;
        break;
      end
    end
    mode[0] = 1;
    mode[1] = 1;
    pulse_start();
    wait_done(ok);
    e = sb.pop_front();
    o = obs();
    ntot++;
    if (!ok || o !== e)
      $display("FAIL start_while_busy: got %h done=%0d want %h", o, ok, e);
    else npass++;
    ntot++;
    if (trig_cnt - base != 128)
      $display("FAIL busy_start_trigs: got %0d want 128", trig_cnt - base);
    else npass++;
    repeat (3) @(negedge clk);
    set_modes(8'h73);
    sb.push_back('{1'b0, 8'h73, 3'd4, 3'd6, 3'd5});
    pulse_start();
    ntot++;
    if (done !== 1'b0 || busy !== 1'b1 || pass_map !== 8'h00)
      $display("FAIL restart_clear: got d%b b%b m%h want d0 b1 m00",
               done, busy, pass_map);
    else npass++;
    wait_done(ok);
    e = sb.pop_front();
    o = obs();
    ntot++;
    if (!ok || o !== e)
      $display("FAIL restart_result: got %h done=%0d want %h", o, ok, e);
    else npass++;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mode[i] = 0;
    test_reset();
    test_all_pass();
    test_window_mid();
    test_two_windows();
    test_no_pass();
    test_bad_sample();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
